filter_pair_arbiter: RTL and testbench
======================================

# filter_pair_arbiter

Sits directly downstream of the filter bank fed by `filter_dispatcher`. Each of the NUM_FILTERS filters emits at most one surviving (in-cutoff) home/neighbour pair per cycle. This block buffers each filter's pairs in a private FIFO and round-robin arbitrates them onto the single force-evaluation pipeline through a valid/ready handshake. It produces the per-filter back-pressure that the dispatcher folds into `o_dispatcher_back_pressure`.

## Interface
- `NUM_FILTERS`, 4, number of filter lanes (≥2)
- `PAIR_WIDTH`, 96, bits per pair word (home parid, nb parid, r2, dx/dy/dz, elements), opaque here
- `FIFO_DEPTH`, 8, entries per lane FIFO, power of two
- `BP_MARGIN`, 3, free-entry headroom covering dispatcher+filter latency
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `i_flush`  in  1  synchronous clear of all FIFOs and output register
- `i_pair_valid`  in  NUM_FILTERS  lane k presents a pair this cycle
- `i_pair_data`  in  NUM_FILTERS×PAIR_WIDTH  lane k pair word, lane k at bits [k*PAIR_WIDTH +: PAIR_WIDTH]
- `i_force_ready`  in  1  force pipeline accepts output this cycle
- `o_pair_valid`  out  1  output register holds a pair
- `o_pair_data`  out  PAIR_WIDTH  pair word
- `o_pair_src`  out  $clog2(NUM_FILTERS)  lane the output came from (selects force accumulator)
- `o_filter_back_pressure`  out  NUM_FILTERS  lane k occupancy ≥ FIFO_DEPTH−BP_MARGIN
- `o_overflow`  out  1  sticky: a pair arrived at a full FIFO
- `o_all_empty`  out  1  all FIFOs empty and output register empty

## Operation
- Per lane: circular FIFO, write/read pointers of $clog2(FIFO_DEPTH) bits that wrap naturally, occupancy counter of $clog2(FIFO_DEPTH)+1 bits.
- Write: `i_pair_valid[k]` with occupancy<FIFO_DEPTH stores the pair. Fullness is judged on pre-edge occupancy; a same-cycle pop on that lane does not free the slot. A write to a full FIFO is dropped and sets `o_overflow`, which is cleared only by reset or `i_flush`.
- Output register load condition: `!o_pair_valid || i_force_ready`.
- When loading, the arbiter scans lanes starting at last_grant+1 (mod NUM_FILTERS) and picks the first non-empty lane. It pops that lane, loads data and src, and updates last_grant. If every lane is empty, `o_pair_valid` goes to 0.
- While `o_pair_valid && !i_force_ready`: data and src are held stable and no pop occurs.
- Simultaneous write and pop on one lane: occupancy stays the same and both pointers advance.
- `i_flush`: pointers, occupancies, `o_pair_valid` and `o_overflow` are cleared, and last_grant resets. Flush beats any same-cycle write.
- `o_filter_back_pressure` and `o_all_empty` are registered from post-edge occupancy.
- Reset values: `o_pair_valid`=0, `o_pair_data`=0, `o_pair_src`=0, `o_filter_back_pressure`=0, `o_overflow`=0, `o_all_empty`=1, last_grant=NUM_FILTERS−1 (so lane 0 gets first priority).
- Reset mid-operation: all queued pairs are lost and outputs take reset values immediately, asynchronously.

## Timing
- Pair presented in cycle N is written at edge N and appears on `o_pair_valid`/`o_pair_data` after edge N+1. Minimum latency is 2 cycles.
- With `i_force_ready` held at 1, throughput is 1 pair/cycle whenever any FIFO is non-empty.
- Back-pressure timing:
  - Asserts the cycle after occupancy reaches FIFO_DEPTH−BP_MARGIN.
  - Upstream may still deliver BP_MARGIN pairs without overflow.
- `o_all_empty` rises one cycle after the final output handshake.

## Configuration
- `PAIR_ARB_STATS_EN` defined:
  - Adds output `o_pairs_dispatched` (32 bits): counts output handshakes, wraps at 2^32, cleared by reset/`i_flush`.
  - Adds output `o_drop_count` (16 bits): counts dropped pairs, saturates at 0xFFFF.
- Undefined: neither port exists and no counter logic is compiled; all other behaviour is identical.

## Test plan
- Single pair: NUM_FILTERS=4, one pair on lane 2 at cycle 5, ready=1 → `o_pair_valid` for exactly one cycle after edge 6, src=2, data matches, then `o_all_empty`=1.
- Round-robin: all 4 lanes valid for 1 cycle, ready=1 → outputs src 0,1,2,3 on consecutive cycles; a second burst starting with last_grant=1 begins at src 2.
- Stall: 3 pairs on lane 0, ready=0 for 10 cycles → output holds first pair unchanged. When ready rises, the 3 pairs drain in order over 3 cycles.
- Back-pressure/overflow: FIFO_DEPTH=8, BP_MARGIN=3, ready=0, lane 1 written every cycle:
  - `o_filter_back_pressure[1]` rises after occupancy hits 5.
  - The ninth pair still in flight after the output register loads is dropped and `o_overflow`=1.
  - With stats enabled, `o_drop_count`=1.
- Flush: lanes partly filled, `i_flush` for one cycle with a concurrent write on lane 3 → next cycle all empty, `o_pair_valid`=0, `o_overflow`=0, lane 3 write discarded.
- Async reset: assert `rst`=0 mid-drain between clock edges → outputs take reset values before the next edge. After release, lane 0 is served first.

Source files
------------

// File: rtl/filter_pair_arbiter.sv
// Per-lane pair FIFOs with a round-robin merge onto the single force-evaluation pipeline.
// Optional PAIR_ARB_STATS_EN adds handshake and drop counters.
module filter_pair_arbiter #(
  parameter int NUM_FILTERS = 4,
  parameter int PAIR_WIDTH  = 96,
  parameter int FIFO_DEPTH  = 8,
  parameter int BP_MARGIN   = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_flush,
  input  logic [NUM_FILTERS-1:0]             i_pair_valid,
  input  logic [NUM_FILTERS*PAIR_WIDTH-1:0]  i_pair_data,
  input  logic                               i_force_ready,
  output logic                               o_pair_valid,
  output logic [PAIR_WIDTH-1:0]              o_pair_data,
  output logic [$clog2(NUM_FILTERS)-1:0]     o_pair_src,
  output logic [NUM_FILTERS-1:0]             o_filter_back_pressure,
  output logic                               o_overflow,
  output logic                               o_all_empty
`ifdef PAIR_ARB_STATS_EN
  ,
  output logic [31:0]                        o_pairs_dispatched,
  output logic [15:0]                        o_drop_count
`endif
);

  localparam int SRC_W = $clog2(NUM_FILTERS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] OCC_BP   = OCC_W'(FIFO_DEPTH - BP_MARGIN);

  logic [PAIR_WIDTH-1:0] mem [NUM_FILTERS][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr   [NUM_FILTERS];
  logic [PTR_W-1:0]      rd_ptr   [NUM_FILTERS];
  logic [OCC_W-1:0]      occ      [NUM_FILTERS];
  logic [OCC_W-1:0]      occ_next [NUM_FILTERS];
  logic [NUM_FILTERS-1:0] wr_en, pop, nonempty, full;
  logic [SRC_W-1:0]      last_grant, grant_idx, cand;
  logic                  grant_found, load, valid_next, all_occ_zero;

  always_comb begin
    load         = !o_pair_valid || i_force_ready;
    grant_found  = 1'b0;
    grant_idx    = '0;
    cand         = '0;
    all_occ_zero = 1'b1;
    for (int i = 0; i < NUM_FILTERS; i++) begin
      nonempty[i] = (occ[i] != '0);
      full[i]     = (occ[i] == OCC_FULL);
      wr_en[i]    = i_pair_valid[i] && !full[i];
    end
    // Scan starts one past the previous winner so every lane gets a turn.
    for (int i = 1; i <= NUM_FILTERS; i++) begin
      cand = SRC_W'((int'(last_grant) + i) % NUM_FILTERS);
      if (!grant_found && nonempty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    valid_next = load ? grant_found : o_pair_valid;
    for (int i = 0; i < NUM_FILTERS; i++) begin
      pop[i]      = load && grant_found && (grant_idx == SRC_W'(i));
      occ_next[i] = occ[i] + OCC_W'(wr_en[i]) - OCC_W'(pop[i]);
      if (occ_next[i] != '0) all_occ_zero = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_FILTERS; k++) begin
      if (wr_en[k] && !i_flush)
        mem[k][wr_ptr[k]] <= i_pair_data[k*PAIR_WIDTH +: PAIR_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_FILTERS; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        occ[k]    <= '0;
      end
      o_pair_valid           <= 1'b0;
      o_pair_data            <= '0;
      o_pair_src             <= '0;
      o_filter_back_pressure <= '0;
      o_overflow             <= 1'b0;
      o_all_empty            <= 1'b1;
      last_grant             <= SRC_W'(NUM_FILTERS - 1);
    end else if (i_flush) begin
      for (int k = 0; k < NUM_FILTERS; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        occ[k]    <= '0;
      end
      o_pair_valid           <= 1'b0;
      o_filter_back_pressure <= '0;
      o_overflow             <= 1'b0;
      o_all_empty            <= 1'b1;
      last_grant             <= SRC_W'(NUM_FILTERS - 1);
    end else begin
      for (int k = 0; k < NUM_FILTERS; k++) begin
        if (wr_en[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
        if (pop[k])   rd_ptr[k] <= rd_ptr[k] + 1'b1;
        occ[k]                    <= occ_next[k];
        o_filter_back_pressure[k] <= (occ_next[k] >= OCC_BP);
      end
      if (|(i_pair_valid & full)) o_overflow <= 1'b1;
      if (load) begin
        o_pair_valid <= grant_found;
        if (grant_found) begin
          o_pair_data <= mem[grant_idx][rd_ptr[grant_idx]];
          o_pair_src  <= grant_idx;
          last_grant  <= grant_idx;
        end
      end
      o_all_empty <= all_occ_zero && !valid_next;
    end
  end

`ifdef PAIR_ARB_STATS_EN
  logic [15:0] drop_num;
  logic [16:0] drop_sum;

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < NUM_FILTERS; i++) begin
      if (i_pair_valid[i] && full[i]) drop_num = drop_num + 16'd1;
    end
    drop_sum = {1'b0, o_drop_count} + {1'b0, drop_num};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_pairs_dispatched <= '0;
      o_drop_count       <= '0;
    end else if (i_flush) begin
      o_pairs_dispatched <= '0;
      o_drop_count       <= '0;
    end else begin
      if (o_pair_valid && i_force_ready) o_pairs_dispatched <= o_pairs_dispatched + 32'd1;
      o_drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_filter_pair_arbiter.sv
// Directed bench for filter_pair_arbiter: vector table for arbitration order plus
// hand sequences for stall, back-pressure/overflow, flush and asynchronous reset.
module tb_filter_pair_arbiter;
  localparam int NF = 4;
  localparam int PW = 96;

  logic               clk;
  logic               rst;
  logic               i_flush;
  logic [NF-1:0]      i_pair_valid;
  logic [NF*PW-1:0]   i_pair_data;
  logic               i_force_ready;
  logic               o_pair_valid;
  logic [PW-1:0]      o_pair_data;
  logic [1:0]         o_pair_src;
  logic [NF-1:0]      o_filter_back_pressure;
  logic               o_overflow;
  logic               o_all_empty;
`ifdef PAIR_ARB_STATS_EN
  logic [31:0]        o_pairs_dispatched;
  logic [15:0]        o_drop_count;
`endif

  filter_pair_arbiter #(.NUM_FILTERS(NF), .PAIR_WIDTH(PW), .FIFO_DEPTH(8), .BP_MARGIN(3)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .i_flush                (i_flush),
    .i_pair_valid           (i_pair_valid),
    .i_pair_data            (i_pair_data),
    .i_force_ready          (i_force_ready),
    .o_pair_valid           (o_pair_valid),
    .o_pair_data            (o_pair_data),
    .o_pair_src             (o_pair_src),
    .o_filter_back_pressure (o_filter_back_pressure),
    .o_overflow             (o_overflow),
    .o_all_empty            (o_all_empty)
`ifdef PAIR_ARB_STATS_EN
    ,
    .o_pairs_dispatched     (o_pairs_dispatched),
    .o_drop_count           (o_drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NF-1:0] v;
    int            tag;
    logic          rdy;
    logic          exp_v;
    int            exp_src;
    int            exp_tag;
    logic          exp_ae;
  } vec_t;

  vec_t tbl [19];

  function automatic logic [PW-1:0] make_data(input int tag, input int k);
    return {32'(tag), 32'(k), 32'hC0DE_0000 + 32'(tag * 16 + k)};
  endfunction

  function automatic vec_t mk(input logic [NF-1:0] v, input int tag, input logic rdy,
                              input logic ev, input int es, input int et, input logic ae);
    vec_t r;
    r.v = v; r.tag = tag; r.rdy = rdy; r.exp_v = ev; r.exp_src = es; r.exp_tag = et; r.exp_ae = ae;
    return r;
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [NF-1:0] v, input int tag, input logic rdy);
    i_pair_valid  = v;
    i_force_ready = rdy;
    for (int k = 0; k < NF; k++) i_pair_data[k*PW +: PW] = make_data(tag, k);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic ev, input int es, input int et);
    chk({name, "_valid"}, PW'(o_pair_valid), PW'(ev));
    if (ev) begin
      chk({name, "_src"}, PW'(o_pair_src), PW'(es));
      chk({name, "_data"}, o_pair_data, make_data(et, es));
    end
  endtask

  initial begin
    rst = 1'b0;
    i_flush = 1'b0;
    drive('0, 0, 1'b0);

    // Arbitration table: round-robin from reset, single pair, then burst after last_grant=1
    tbl[0]  = mk(4'h0, 0, 1, 0, 0, 0, 1);
    tbl[1]  = mk(4'hF, 2, 1, 0, 0, 0, 0);
    tbl[2]  = mk(4'h0, 0, 1, 1, 0, 2, 0);
    tbl[3]  = mk(4'h0, 0, 1, 1, 1, 2, 0);
    tbl[4]  = mk(4'h0, 0, 1, 1, 2, 2, 0);
    tbl[5]  = mk(4'h0, 0, 1, 1, 3, 2, 0);
    tbl[6]  = mk(4'h0, 0, 1, 0, 0, 0, 1);
    tbl[7]  = mk(4'h4, 3, 1, 0, 0, 0, 0);
    tbl[8]  = mk(4'h0, 0, 1, 1, 2, 3, 0);
    tbl[9]  = mk(4'h0, 0, 1, 0, 0, 0, 1);
    tbl[10] = mk(4'h2, 4, 1, 0, 0, 0, 0);
    tbl[11] = mk(4'h0, 0, 1, 1, 1, 4, 0);
    tbl[12] = mk(4'h0, 0, 1, 0, 0, 0, 1);
    tbl[13] = mk(4'hF, 5, 1, 0, 0, 0, 0);
    tbl[14] = mk(4'h0, 0, 1, 1, 2, 5, 0);
    tbl[15] = mk(4'h0, 0, 1, 1, 3, 5, 0);
    tbl[16] = mk(4'h0, 0, 1, 1, 0, 5, 0);
    tbl[17] = mk(4'h0, 0, 1, 1, 1, 5, 0);
    tbl[18] = mk(4'h0, 0, 1, 0, 0, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", PW'(o_pair_valid), '0);
    chk("rst_data", o_pair_data, '0);
    chk("rst_src", PW'(o_pair_src), '0);
    chk("rst_bp", PW'(o_filter_back_pressure), '0);
    chk("rst_ovf", PW'(o_overflow), '0);
    chk("rst_all_empty", PW'(o_all_empty), PW'(1));
    rst = 1'b1;

    for (int n = 0; n < 19; n++) begin
      drive(tbl[n].v, tbl[n].tag, tbl[n].rdy);
      step();
      chk_out($sformatf("vec%0d", n), tbl[n].exp_v, tbl[n].exp_src, tbl[n].exp_tag);
      chk($sformatf("vec%0d_all_empty", n), PW'(o_all_empty), PW'(tbl[n].exp_ae));
      chk($sformatf("vec%0d_bp", n), PW'(o_filter_back_pressure), '0);
    end

    // Stall: three pairs on lane 0 with the pipeline not ready
    for (int i = 0; i < 3; i++) begin
      drive(4'h1, 10 + i, 1'b0);
      step();
    end
    drive('0, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out($sformatf("stall%0d", i), 1'b1, 0, 10);
    end
    drive('0, 0, 1'b1);
    for (int i = 1; i < 3; i++) begin
      step();
      chk_out($sformatf("drain%0d", i), 1'b1, 0, 10 + i);
    end
    step();
    chk_out("drain_end", 1'b0, 0, 0);
    chk("drain_all_empty", PW'(o_all_empty), PW'(1));

    // Back-pressure and overflow on lane 1: register takes one pair, FIFO holds eight more
    for (int i = 0; i < 10; i++) begin
      drive(4'h2, 20 + i, 1'b0);
      step();
      chk($sformatf("bp%0d", i), PW'(o_filter_back_pressure), PW'((i >= 5) ? 4'h2 : 4'h0));
      chk($sformatf("ovf%0d", i), PW'(o_overflow), PW'(i == 9));
    end
    chk_out("bp_head", 1'b1, 1, 20);
`ifdef PAIR_ARB_STATS_EN
    chk("drop_count", PW'(o_drop_count), PW'(1));
`endif

    // Flush with a concurrent lane 3 write
    i_flush = 1'b1;
    drive(4'h8, 99, 1'b0);
    step();
    i_flush = 1'b0;
    chk_out("flush", 1'b0, 0, 0);
    chk("flush_ovf", PW'(o_overflow), '0);
    chk("flush_all_empty", PW'(o_all_empty), PW'(1));
    chk("flush_bp", PW'(o_filter_back_pressure), '0);
    drive('0, 0, 1'b1);
    step();
    chk_out("post_flush", 1'b0, 0, 0);
    chk("post_flush_all_empty", PW'(o_all_empty), PW'(1));

    // Asynchronous reset mid-drain, then lane 0 must win over lane 1
    drive(4'h5, 30, 1'b1);
    step();
    drive('0, 0, 1'b1);
    step();
    chk_out("pre_areset", 1'b1, 0, 30);
    #2 rst = 1'b0;
    #1;
    chk("areset_valid", PW'(o_pair_valid), '0);
    chk("areset_data", o_pair_data, '0);
    chk("areset_src", PW'(o_pair_src), '0);
    chk("areset_all_empty", PW'(o_all_empty), PW'(1));
    #2 rst = 1'b1;
    drive(4'h3, 40, 1'b1);
    step();
    chk_out("rel_write", 1'b0, 0, 0);
    drive('0, 0, 1'b1);
    step();
    chk_out("rel_first", 1'b1, 0, 40);
    step();
    chk_out("rel_second", 1'b1, 1, 40);
    step();
    chk_out("rel_end", 1'b0, 0, 0);
    chk("rel_all_empty", PW'(o_all_empty), PW'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
